// File: rtl/opf_pkg.sv
// opf_pkg: shared sizes and bundle types for the operand-fetch stage.
// Imported by the scoreboard and the stage top.
package opf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    reg_idx_t        rd;
    logic            rd_we;
    logic [XLEN-1:0] pc;
  } opf_slot_t;

  // x0 is hardwired, so it never takes part in hazards
  function automatic logic is_nz(input reg_idx_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register.
// A set in the same cycle as a clear or kill of that register wins.
module reg_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [$clog2(NREG)-1:0]  set_idx,
  input  logic                     clr_en,
  input  logic [$clog2(NREG)-1:0]  clr_idx,
  input  logic                     kill_en,
  input  logic [$clog2(NREG)-1:0]  kill_idx,
  output logic [NREG-1:0]          busy_o
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // next busy vector: clears first, then the set overrides
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en)
      w_busy_nxt[clr_idx] = 1'b0;
    if (kill_en)
      w_busy_nxt[kill_idx] = 1'b0;
    if (set_en)
      w_busy_nxt[set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // busy state register, wiped on reset
  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads sources from the register file, bypasses the
// same-cycle writeback, stalls on RAW/WAW and fills one output slot.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREG)-1:0]  in_rs1,
  input  logic [$clog2(NREG)-1:0]  in_rs2,
  input  logic [$clog2(NREG)-1:0]  in_rd,
  input  logic                     in_rd_we,
  input  logic [XLEN-1:0]          in_pc,
  output logic [$clog2(NREG)-1:0]  rf_raddr_a,
  output logic [$clog2(NREG)-1:0]  rf_raddr_b,
  input  logic [XLEN-1:0]          rf_rdata_a,
  input  logic [XLEN-1:0]          rf_rdata_b,
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_rs1_val,
  output logic [XLEN-1:0]          out_rs2_val,
  output logic [$clog2(NREG)-1:0]  out_rd,
  output logic                     out_rd_we,
  output logic [XLEN-1:0]          out_pc
);

  import opf_pkg::*;

  localparam int IW = $clog2(NREG);

  logic [NREG-1:0] w_busy;
  logic            w_wb_a;
  logic            w_wb_b;
  logic            w_clr_rs1;
  logic            w_clr_rs2;
  logic            w_clr_rd;
  logic            w_src1_ok;
  logic            w_src2_ok;
  logic            w_dst_wr;
  logic            w_dst_ok;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_set_en;
  logic            w_clr_en;
  logic            w_kill_en;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  opf_slot_t       w_slot_nxt;
  opf_slot_t       r_slot;
  logic            r_valid;

  assign rf_raddr_a = in_rs1;
  assign rf_raddr_b = in_rs2;

  // the regfile does not forward its own write, so bypass it here
  assign w_wb_a = wb_we && (wb_rd == in_rs1);
  assign w_wb_b = wb_we && (wb_rd == in_rs2);

  // a writeback this cycle releases the busy bit it targets
  assign w_clr_rs1 = w_wb_a && is_nz(in_rs1);
  assign w_clr_rs2 = w_wb_b && is_nz(in_rs2);
  assign w_clr_rd  = wb_we && (wb_rd == in_rd)
                     && is_nz(in_rd);

  // resolve each source: x0, then bypass, then regfile
  always_comb begin
    w_rs1_val = rf_rdata_a;
    if (!is_nz(in_rs1))
      w_rs1_val = '0;
    else if (w_wb_a)
      w_rs1_val = wb_data;
  end

  // same resolution for the second source
  always_comb begin
    w_rs2_val = rf_rdata_b;
    if (!is_nz(in_rs2))
      w_rs2_val = '0;
    else if (w_wb_b)
      w_rs2_val = wb_data;
  end

  assign w_src1_ok = !w_busy[in_rs1] || w_clr_rs1;
  assign w_src2_ok = !w_busy[in_rs2] || w_clr_rs2;
  assign w_dst_wr  = in_rd_we && is_nz(in_rd);
  assign w_dst_ok  = !w_dst_wr || !w_busy[in_rd]
                     || w_clr_rd;

  assign w_slot_free = !r_valid || out_ready || flush;

  // ready is independent of in_valid; flush blocks intake
  assign in_ready = w_slot_free && w_src1_ok
                    && w_src2_ok && w_dst_ok && !flush;
  assign w_accept = in_valid && in_ready;

  // assemble the bundle that an accept loads into the slot
  always_comb begin
    w_slot_nxt         = '0;
    w_slot_nxt.rs1_val = w_rs1_val;
    w_slot_nxt.rs2_val = w_rs2_val;
    w_slot_nxt.rd      = in_rd;
    w_slot_nxt.rd_we   = in_rd_we;
    w_slot_nxt.pc      = in_pc;
  end

  assign w_set_en  = w_accept && w_dst_wr;
  assign w_clr_en  = wb_we && is_nz(wb_rd);

  // a flushed slot never writes back, so release its claim
  assign w_kill_en = flush && r_valid && r_slot.rd_we
                     && is_nz(r_slot.rd);

  reg_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (w_set_en),
    .set_idx  (in_rd),
    .clr_en   (w_clr_en),
    .clr_idx  (wb_rd),
    .kill_en  (w_kill_en),
    .kill_idx (r_slot.rd),
    .busy_o   (w_busy)
  );

  // output slot: refill on accept, drain on pop or flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_slot  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_slot  <= w_slot_nxt;
    end else if (flush || out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_rs1_val = r_slot.rs1_val;
  assign out_rs2_val = r_slot.rs2_val;
  assign out_rd      = r_slot.rd;
  assign out_rd_we   = r_slot.rd_we;
  assign out_pc      = r_slot.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus random traffic, checked
// against a scoreboard-level model of the operand-fetch stage.
module tb_operand_fetch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rf_raddr_a;
  logic [4:0]      rf_raddr_b;
  logic [XLEN-1:0] rf_rdata_a;
  logic [XLEN-1:0] rf_rdata_b;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic [XLEN-1:0] out_pc;

  operand_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .in_pc       (in_pc),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // register file stand-in with an override for directed cases
  logic [XLEN-1:0] regs [32];
  logic            ovr;
  logic [XLEN-1:0] ovr_a;
  logic [XLEN-1:0] ovr_b;

  always_comb begin
    if (ovr) begin
      rf_rdata_a = ovr_a;
      rf_rdata_b = ovr_b;
    end else begin
      rf_rdata_a = (rf_raddr_a == 5'd0) ? '0 : regs[rf_raddr_a];
      rf_rdata_b = (rf_raddr_b == 5'd0) ? '0 : regs[rf_raddr_b];
    end
  end

  // model state: pending-writer set and the expected slot
  bit              m_busy [32];
  bit              m_valid;
  logic [XLEN-1:0] m_v1;
  logic [XLEN-1:0] m_v2;
  logic [XLEN-1:0] m_pc;
  logic [4:0]      m_rd;
  bit              m_we;
  bit              last_acc;
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string tag,
                     input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_hits(input logic [4:0] r);
    return wb_we && (wb_rd == r) && (r != 5'd0);
  endfunction

  function automatic bit pending(input logic [4:0] r);
    return m_busy[r] && !wb_hits(r);
  endfunction

  function automatic bit exp_ready();
    bit blocked;
    blocked = pending(in_rs1) || pending(in_rs2);
    if (in_rd_we && in_rd != 5'd0 && pending(in_rd))
      blocked = 1'b1;
    if (m_valid && !out_ready)
      blocked = 1'b1;
    return !blocked && !flush;
  endfunction

  function automatic logic [XLEN-1:0] opnd(
    input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return '0;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // one clock: check at negedge, advance model, apply regfile write
  task automatic cyc();
    bit              rdy;
    bit              acc;
    bit              wbw;
    logic [4:0]      wbr;
    logic [XLEN-1:0] wbd;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    @(negedge clk);
    rdy = exp_ready();
    if (!reset) begin
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_valid);
      chk("raddr_a", rf_raddr_a, in_rs1);
      chk("raddr_b", rf_raddr_b, in_rs2);
      if (m_valid) begin
        chk("slot_rs1", out_rs1_val, m_v1);
        chk("slot_rs2", out_rs2_val, m_v2);
        chk("slot_rd", out_rd, m_rd);
        chk("slot_we", out_rd_we, m_we);
        chk("slot_pc", out_pc, m_pc);
      end
    end
    e1 = opnd(in_rs1, rf_rdata_a);
    e2 = opnd(in_rs2, rf_rdata_b);
    acc = !reset && in_valid && rdy;
    last_acc = acc;
    wbw = wb_we;
    wbr = wb_rd;
    wbd = wb_data;
    if (reset) begin
      m_valid = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (flush && m_valid && m_we && m_rd != 5'd0)
        m_busy[m_rd] = 1'b0;
      if (wbw && wbr != 5'd0)
        m_busy[wbr] = 1'b0;
      if (acc && in_rd_we && in_rd != 5'd0)
        m_busy[in_rd] = 1'b1;
      if (acc) begin
        m_valid = 1'b1;
        m_v1 = e1;
        m_v2 = e2;
        m_rd = in_rd;
        m_we = in_rd_we;
        m_pc = in_pc;
      end else if (flush || out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    if (wbw && wbr != 5'd0)
      regs[wbr] = wbd;
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd,
                       input logic we,
                       input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
    in_pc    = pc;
  endtask

  task automatic wb(input logic [4:0] rd,
                    input logic [XLEN-1:0] d);
    wb_we   = 1'b1;
    wb_rd   = rd;
    wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      regs[i] = 32'h0101_0101 * i;
    ovr = 1'b0; ovr_a = '0; ovr_b = '0;
    reset = 1'b1; in_valid = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rd_we = 1'b0; in_pc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_we = 1'b0;
    m_v1 = '0; m_v2 = '0; m_pc = '0; m_rd = '0;

    // reset values
    @(posedge clk); #1;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_rs1", out_rs1_val, 0);
    chk("rst_rs2", out_rs2_val, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_we", out_rd_we, 0);
    chk("rst_pc", out_pc, 0);

    // hazard-free stream at full rate
    ovr = 1'b1; ovr_a = 32'h11; ovr_b = 32'h22;
    for (int i = 0; i < 4; i++) begin
      issue(5'd10, 5'd11, 5'(i + 1), 1'b1, 32'(32'h100 + 4 * i));
      cyc();
      chk("nh_acc", last_acc, 1);
      chk("nh_valid", out_valid, 1);
      chk("nh_rs1", out_rs1_val, 32'h11);
      chk("nh_rs2", out_rs2_val, 32'h22);
      chk("nh_pc", out_pc, 32'(32'h100 + 4 * i));
    end
    in_valid = 1'b0; ovr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb(5'(i), 32'(32'hA0 + i));
      cyc();
    end
    wb_we = 1'b0;

    // RAW stall released by the writeback cycle
    issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h200);
    cyc();
    chk("raw_p_acc", last_acc, 1);
    issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h204);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("raw_stall", last_acc, 0);
    end
    wb(5'd5, 32'hDEAD);
    cyc();
    chk("raw_acc", last_acc, 1);
    chk("raw_op", out_rs1_val, 32'hDEAD);
    wb_we = 1'b0; in_valid = 1'b0;
    cyc();

    // x0 never becomes busy and always reads zero
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h300);
    cyc();
    chk("x0_acc1", last_acc, 1);
    ovr = 1'b1; ovr_a = '1; ovr_b = '1;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h304);
    cyc();
    chk("x0_acc2", last_acc, 1);
    chk("x0_rs1", out_rs1_val, 0);
    chk("x0_rs2", out_rs2_val, 0);
    ovr = 1'b0; in_valid = 1'b0;
    cyc();

    // backpressure holds the slot, then pop and refill together
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd0, 1'b0, 32'h400);
    cyc();
    chk("bp_acc", last_acc, 1);
    issue(5'd3, 5'd4, 5'd0, 1'b0, 32'h404);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_stall", last_acc, 0);
      chk("bp_hold", out_pc, 32'h400);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_refill", last_acc, 1);
    chk("bp_pc", out_pc, 32'h404);
    chk("bp_valid2", out_valid, 1);
    in_valid = 1'b0;
    cyc();

    // flush drops the slot and frees its destination
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h500);
    cyc();
    chk("fl_acc", last_acc, 1);
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    out_ready = 1'b1;
    issue(5'd7, 5'd0, 5'd0, 1'b0, 32'h504);
    cyc();
    chk("fl_nostall", last_acc, 1);
    in_valid = 1'b0;
    cyc();

    // set beats clear on the same register
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h600);
    cyc();
    chk("col_acc1", last_acc, 1);
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h604);
    wb(5'd9, 32'h99);
    cyc();
    chk("col_acc2", last_acc, 1);
    wb_we = 1'b0;
    issue(5'd9, 5'd0, 5'd0, 1'b0, 32'h608);
    cyc();
    chk("col_busy", last_acc, 0);
    wb(5'd9, 32'h999);
    cyc();
    chk("col_clr", last_acc, 1);
    chk("col_op", out_rs1_val, 32'h999);
    wb_we = 1'b0; in_valid = 1'b0;
    cyc();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_rd_we  = 1'($urandom_range(0, 1));
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      reset     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0; in_valid = 1'b0;
    wb_we = 1'b0; flush = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
